// File: rtl/mem_stage_pkg.sv
// Shared opcode/size encodings and the memory-stage state type.
package mem_stage_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] LDSZ_B = 2'b00;
    localparam logic [1:0] LDSZ_H = 2'b01;
    localparam logic [1:0] LDSZ_W = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus: req/gnt request phase plus rvalid read-data phase.
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Byte-enable / store-lane replication and load extract with sign or zero extension.
module lsu_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  i_ldsz,
    input  logic [1:0]  i_shift,
    input  logic        i_unsigned,
    input  logic [31:0] i_x2,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata
);
    logic [31:0] w_shifted;

    always_comb begin
        w_shifted = i_rdata >> {i_shift, 3'b000};
        o_be      = 4'b1111;
        o_wdata   = i_x2;
        o_ldata   = w_shifted;
        case (i_ldsz)
            LDSZ_B: begin
                o_be    = 4'b0001 << i_shift;
                o_wdata = {4{i_x2[7:0]}};
                o_ldata = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
            end
            LDSZ_H: begin
                o_be    = 4'b0011 << i_shift;
                o_wdata = {2{i_x2[15:0]}};
                o_ldata = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: one instruction slot, data-memory handshake FSM with timeout, WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        valid_EX,
    input  logic [6:0]  opcode_EX,
    input  logic [4:0]  rd_EX,
    input  logic [31:0] res_EX,
    input  logic [31:0] x2_EX,
    input  logic [1:0]  ldsz,
    input  logic [1:0]  ldshift,
    input  logic        ld_unsigned,
    input  logic        trap_EX,
    output logic        stall,
    output logic [4:0]  rd_MEM,
    output logic [31:0] res_MEM,
    mem_stage_if.master dmem,
    output logic [4:0]  rd_WB,
    output logic [31:0] res_WB,
    output logic        trap_WB
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    mem_state_t  r_state;
    logic        r_valid;
    logic        r_store;
    logic        r_trap;
    logic [4:0]  r_rd;
    logic [31:0] r_res;
    logic [31:0] r_x2;
    logic [1:0]  r_ldsz;
    logic [1:0]  r_ldshift;
    logic        r_unsigned;
    logic [CW-1:0] r_cnt;

    logic [CW-1:0] w_cnt_inc;
    logic          w_cnt_expired;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_ldata;
    logic          w_is_mem;

    lsu_align u_align (
        .i_ldsz     (r_ldsz),
        .i_shift    (r_ldshift),
        .i_unsigned (r_unsigned),
        .i_x2       (r_x2),
        .i_rdata    (dmem.dmem_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_ldata    (w_ldata)
    );

    assign w_cnt_inc     = r_cnt + CW'(1);
    assign w_cnt_expired = (w_cnt_inc == CW'(TIMEOUT));
    assign w_is_mem      = (opcode_EX == OPC_LOAD) || (opcode_EX == OPC_STORE);

    assign stall   = (r_state == S_REQ) || (r_state == S_RESP);
    assign rd_MEM  = (!stall && r_valid && !r_trap && !r_store) ? r_rd : '0;
    assign res_MEM = r_res;

    // Bus fields are only driven while requesting so the bus idles at zero.
    assign dmem.dmem_req   = (r_state == S_REQ);
    assign dmem.dmem_we    = (r_state == S_REQ) && r_store;
    assign dmem.dmem_addr  = (r_state == S_REQ) ? {r_res[31:2], 2'b00} : '0;
    assign dmem.dmem_be    = (r_state == S_REQ) ? w_be : '0;
    assign dmem.dmem_wdata = (r_state == S_REQ) ? w_wdata : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_valid    <= 1'b0;
            r_store    <= 1'b0;
            r_trap     <= 1'b0;
            r_rd       <= '0;
            r_res      <= '0;
            r_x2       <= '0;
            r_ldsz     <= '0;
            r_ldshift  <= '0;
            r_unsigned <= 1'b0;
            r_cnt      <= '0;
            rd_WB      <= '0;
            res_WB     <= '0;
            trap_WB    <= 1'b0;
        end else begin
            rd_WB   <= stall ? '0 : rd_MEM;
            res_WB  <= res_MEM;
            trap_WB <= !stall && r_valid && r_trap;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_valid    <= valid_EX && !flush;
                    r_store    <= (opcode_EX == OPC_STORE);
                    r_trap     <= trap_EX;
                    r_rd       <= rd_EX;
                    r_res      <= res_EX;
                    r_x2       <= x2_EX;
                    r_ldsz     <= ldsz;
                    r_ldshift  <= ldshift;
                    r_unsigned <= ld_unsigned;
                    r_cnt      <= '0;
                    if (valid_EX && !flush && !trap_EX && w_is_mem)
                        r_state <= S_REQ;
                    else
                        r_state <= S_IDLE;
                end
                S_REQ: begin
                    if (dmem.dmem_gnt) begin
                        r_cnt   <= '0;
                        r_state <= r_store ? S_DONE : S_RESP;
                    end else if (w_cnt_expired) begin
                        r_trap  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_RESP: begin
                    if (dmem.dmem_rvalid) begin
                        r_res   <= w_ldata;
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else if (w_cnt_expired) begin
                        r_trap  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
